wb_select_stage: RTL and testbench
==================================

// Module: wb_select_stage
// PURPOSE
//  Registered write-back stage of the pipelined CPU; replaces the purely combinational write-back mux.
//  Accepts one retiring instruction per handshake from MEM and picks one source: ALU, load data, PC+PC_INC or immediate.
//  Loads stall until the data memory returns a response; load bytes/halves are aligned and sign/zero-extended here.
//  Drives the register-file write port with a one-cycle write pulse, plus a memory-timeout error pulse.
// PARAMETERS
//  XLEN        32  datapath width (power of 2, >=32)
//  RA_W        5   register address width
//  PC_INC      4   increment added to PC for sel=2'b10 (link address)
//  MEM_TIMEOUT 0   max WAIT cycles before abort; 0 = wait forever
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst_n       in   1     asynchronous active-low reset
//  flush       in   1     kill accept/in-flight op; no write results
//  in_valid    in   1     MEM stage presents an instruction
//  in_ready    out  1     stage can accept; combinational = (state==IDLE)
//  in_sel      in   2     00 ALU, 01 load, 10 PC+PC_INC, 11 immediate
//  in_we       in   1     instruction writes rd
//  in_rd       in   RA_W  destination register
//  in_pc       in   XLEN  instruction PC
//  in_alu      in   XLEN  ALU result
//  in_imm      in   XLEN  immediate (LUI path)
//  in_funct3   in   3     load format: 000 LB,001 LH,010 LW,100 LBU,101 LHU
//  in_addr_lo  in   2     load address bits [1:0]
//  mem_rvalid  in   1     load data valid (sampled only in WAIT)
//  mem_rdata   in   XLEN  raw load word
//  regW_en     out  1     register-file write strobe (1-cycle pulse)
//  regW_addr   out  RA_W  write address
//  regW_data   out  XLEN  write data
//  err_timeout out  1     1-cycle pulse when a load is aborted by timeout
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0; regW_en=0, regW_addr=0, regW_data=0, err_timeout=0. Async assert, sync deassert.
//  - States: IDLE, WAIT. Accept = in_valid & in_ready & !flush.
//  - IDLE, accept, sel!=01: next edge regW_en=in_we&(in_rd!=0); addr/data registered. Latency 1.
//  - Data: 00 in_alu; 10 in_pc+PC_INC, truncated mod 2^XLEN; 11 in_imm.
//  - IDLE, accept, sel=01: latch rd/we/funct3/addr_lo; go to WAIT; counter cleared.
//  - WAIT & mem_rvalid & !flush: next edge write extracted data as above; return to IDLE.
//  - in_ready=0 throughout WAIT, including the rvalid cycle; the next accept is at the earliest on the following cycle.
//  - Extraction: byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored for halves.
//    LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW = rdata[31:0], sign-extended to XLEN.
//    Undefined funct3 values are treated as LW.
//  - rd==0 or we==0: the load still waits for rvalid; regW_en stays 0.
//  - mem_rvalid in IDLE is ignored.
//  - flush has priority over accept and over rvalid: no accept, WAIT->IDLE, no regW_en.
//    A flush-aborted response that arrives later is ignored (IDLE).
//  - Timeout (MEM_TIMEOUT>0): counter increments each WAIT cycle without rvalid.
//    When it reaches MEM_TIMEOUT: err_timeout=1 for one cycle, go to IDLE, no write.
//    rvalid in that same cycle wins: write, no error.
//  - regW_en is 0 in every cycle not listed above; regW_addr/data hold their last value.
//  - Reset mid-WAIT discards the load; no write after release.
// TESTING
//  1 ALU: sel=00, alu=0x12345678, rd=5, we=1
//    -> next cycle regW_en=1, addr=5, data=0x12345678; following cycle en=0.
//  2 Link wrap: sel=10, pc=0xFFFFFFFC -> data=0x00000000.
//    Imm: sel=11, imm=0xABCD0000 -> data=0xABCD0000.
//  3 Load, rvalid 3 cycles after accept, rdata=0x00800000, addr_lo=2, rd=7:
//    LB -> 0xFFFFFF80; LBU -> 0x00000080; in_ready=0 for those cycles.
//    LH, addr_lo=2, rdata=0x80010000 -> 0xFFFF8001.
//  4 rd=0 ALU op -> no regW_en. Back-to-back ALU ops on consecutive cycles -> consecutive write pulses.
//  5 Flush in WAIT, then rvalid 2 cycles later -> no write; in_ready=1 the cycle after flush.
//    Flush with in_valid in IDLE -> not accepted.
//  6 MEM_TIMEOUT=8, no rvalid -> err_timeout pulse 8 cycles after entering WAIT, no write.
//    rst_n low mid-WAIT -> all outputs 0 immediately; no write after release.

Source files
------------

// File: rtl/wb_select_stage.sv
// Registered write-back stage: selects ALU / load / link / immediate result and
// drives a one-cycle register-file write pulse; loads wait for the memory response.
module wb_select_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RA_W        = 5,
    parameter int unsigned PC_INC      = 4,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sel,
    input  logic            in_we,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            regW_en,
    output logic [RA_W-1:0] regW_addr,
    output logic [XLEN-1:0] regW_data,
    output logic            err_timeout
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [RA_W-1:0] ld_rd;
    logic            ld_we;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_addr_lo;
    logic [CNT_W-1:0] cnt;

    logic [XLEN-1:0] sel_data_c;
    logic [XLEN-1:0] load_data_c;
    logic [7:0]      ld_byte_c;
    logic [15:0]     ld_half_c;
    logic [31:0]     ld_word_c;
    logic            timeout_hit_c;

    assign in_ready = (state == S_IDLE);

    // Non-load result select; link address wraps modulo 2^XLEN
    always_comb begin
        sel_data_c = in_alu;
        case (in_sel)
            2'b10:   sel_data_c = in_pc + XLEN'(PC_INC);
            2'b11:   sel_data_c = in_imm;
            default: sel_data_c = in_alu;
        endcase
    end

    // Load alignment and extension; halves ignore addr_lo[0]
    always_comb begin
        ld_byte_c   = mem_rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half_c   = mem_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
        ld_word_c   = mem_rdata[31:0];
        load_data_c = XLEN'($signed(ld_word_c));
        case (ld_funct3)
            3'b000:  load_data_c = XLEN'($signed(ld_byte_c));
            3'b001:  load_data_c = XLEN'($signed(ld_half_c));
            3'b100:  load_data_c = XLEN'(ld_byte_c);
            3'b101:  load_data_c = XLEN'(ld_half_c);
            default: load_data_c = XLEN'($signed(ld_word_c));
        endcase
    end

    assign timeout_hit_c = (MEM_TIMEOUT != 0) && (32'(cnt) == (MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ld_rd       <= '0;
            ld_we       <= 1'b0;
            ld_funct3   <= '0;
            ld_addr_lo  <= '0;
            cnt         <= '0;
            regW_en     <= 1'b0;
            regW_addr   <= '0;
            regW_data   <= '0;
            err_timeout <= 1'b0;
        end else begin
            regW_en     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        if (in_sel == 2'b01) begin
                            ld_rd      <= in_rd;
                            ld_we      <= in_we;
                            ld_funct3  <= in_funct3;
                            ld_addr_lo <= in_addr_lo;
                            cnt        <= '0;
                            state      <= S_WAIT;
                        end else begin
                            regW_en   <= in_we && (in_rd != '0);
                            regW_addr <= in_rd;
                            regW_data <= sel_data_c;
                        end
                    end
                end
                S_WAIT: begin
                    // flush beats a same-cycle response; response beats timeout
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (mem_rvalid) begin
                        regW_en   <= ld_we && (ld_rd != '0);
                        regW_addr <= ld_rd;
                        regW_data <= load_data_c;
                        state     <= S_IDLE;
                    end else if (timeout_hit_c) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: expected writes are queued at drive time
// and compared against writes captured by a monitor.
module tb_wb_select_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    typedef struct packed {
        logic [RA_W-1:0] addr;
        logic [XLEN-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_sel;
    logic            in_we;
    logic [RA_W-1:0] in_rd;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_imm;
    logic [2:0]      in_funct3;
    logic [1:0]      in_addr_lo;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            regW_en;
    logic [RA_W-1:0] regW_addr;
    logic [XLEN-1:0] regW_data;
    logic            err_timeout;

    int errors = 0;
    int checks = 0;

    wr_t exp_q[$];
    wr_t obs_mem [256];
    int  obs_cyc [256];
    int  obs_n = 0;
    int  obs_rd = 0;
    int  err_n = 0;
    int  cyc = 0;

    wb_select_stage #(.XLEN(XLEN), .RA_W(RA_W), .PC_INC(4), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_we(in_we), .in_rd(in_rd), .in_pc(in_pc), .in_alu(in_alu),
        .in_imm(in_imm), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .regW_en(regW_en),
        .regW_addr(regW_addr), .regW_data(regW_data), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Monitor: record every write pulse and timeout pulse, sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && regW_en && obs_n < 256) begin
            obs_mem[obs_n] <= '{addr: regW_addr, data: regW_data};
            obs_cyc[obs_n] <= cyc;
            obs_n          <= obs_n + 1;
        end
        if (rst_n && err_timeout) err_n <= err_n + 1;
    end

    task automatic drive_op(input logic [1:0] sel, input logic we, input logic [RA_W-1:0] rd,
                            input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu,
                            input logic [XLEN-1:0] imm, input logic [2:0] f3, input logic [1:0] alo);
        @(posedge clk); #1;
        in_valid = 1'b1; in_sel = sel; in_we = we; in_rd = rd; in_pc = pc;
        in_alu = alu; in_imm = imm; in_funct3 = f3; in_addr_lo = alo;
    endtask

    task automatic release_bus();
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    // Load accepted from IDLE; response presented in WAIT cycle dly (dly >= 1)
    task automatic load_op(input logic [2:0] f3, input logic [1:0] alo, input logic [XLEN-1:0] rdata,
                           input logic [RA_W-1:0] rd, input int dly);
        drive_op(2'b01, 1'b1, rd, '0, '0, '0, f3, alo);
        release_bus();
        repeat (dly - 1) @(posedge clk);
        #1; mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = '0; in_we = 1'b0; in_rd = '0;
        in_pc = '0; in_alu = '0; in_imm = '0; in_funct3 = '0; in_addr_lo = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (regW_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", regW_en); end
        checks++; if (regW_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", regW_addr); end
        checks++; if (regW_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", regW_data); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_alu();
        drive_op(2'b00, 1'b1, 5'd5, '0, 32'h1234_5678, '0, 3'b000, 2'b00);
        exp_q.push_back('{addr: 5'd5, data: 32'h1234_5678});
        release_bus();
        @(negedge clk);
        checks++; if (regW_en !== 1'b1) begin errors++; $display("FAIL alu_en: got %b want 1", regW_en); end
        @(negedge clk);
        checks++; if (regW_en !== 1'b0) begin errors++; $display("FAIL alu_en_drop: got %b want 0", regW_en); end
        repeat (2) @(negedge clk);
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin errors++; $display("FAIL alu_count: got %0d writes want %0d", obs_n - obs_rd, exp_q.size()); end
        while (exp_q.size() != 0 && obs_rd < obs_n) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_mem[obs_rd] !== e) begin errors++; $display("FAIL alu_write: got rd=%0d data=%h want rd=%0d data=%h", obs_mem[obs_rd].addr, obs_mem[obs_rd].data, e.addr, e.data); end
            obs_rd++;
        end
        exp_q.delete(); obs_rd = obs_n;
    endtask

    task automatic test_link_imm();
        drive_op(2'b10, 1'b1, 5'd1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, '0, 3'b000, 2'b00);
        exp_q.push_back('{addr: 5'd1, data: 32'h0000_0000});
        drive_op(2'b11, 1'b1, 5'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'hABCD_0000, 3'b000, 2'b00);
        exp_q.push_back('{addr: 5'd2, data: 32'hABCD_0000});
        drive_op(2'b10, 1'b1, 5'd3, 32'h0000_1000, '0, '0, 3'b000, 2'b00);
        exp_q.push_back('{addr: 5'd3, data: 32'h0000_1004});
        release_bus();
        repeat (3) @(negedge clk);
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin errors++; $display("FAIL link_count: got %0d writes want %0d", obs_n - obs_rd, exp_q.size()); end
        while (exp_q.size() != 0 && obs_rd < obs_n) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_mem[obs_rd] !== e) begin errors++; $display("FAIL link_write: got rd=%0d data=%h want rd=%0d data=%h", obs_mem[obs_rd].addr, obs_mem[obs_rd].data, e.addr, e.data); end
            obs_rd++;
        end
        exp_q.delete(); obs_rd = obs_n;
    endtask

    task automatic test_load();
        // First load checked cycle by cycle: in_ready low through the response cycle
        drive_op(2'b01, 1'b1, 5'd7, '0, '0, '0, 3'b000, 2'b10);
        exp_q.push_back('{addr: 5'd7, data: 32'hFFFF_FF80});
        release_bus();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin mem_rvalid = 1'b1; mem_rdata = 32'h0080_0000; end
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_ready_c%0d: got %b want 0", k, in_ready); end
            checks++; if (regW_en !== 1'b0) begin errors++; $display("FAIL load_early_c%0d: got %b want 0", k, regW_en); end
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (regW_en !== 1'b1) begin errors++; $display("FAIL load_en: got %b want 1", regW_en); end
        load_op(3'b100, 2'b10, 32'h0080_0000, 5'd7, 3);
        exp_q.push_back('{addr: 5'd7, data: 32'h0000_0080});
        load_op(3'b001, 2'b10, 32'h8001_0000, 5'd8, 3);
        exp_q.push_back('{addr: 5'd8, data: 32'hFFFF_8001});
        load_op(3'b101, 2'b11, 32'h8001_0000, 5'd9, 1);
        exp_q.push_back('{addr: 5'd9, data: 32'h0000_8001});
        load_op(3'b000, 2'b00, 32'h1234_567F, 5'd10, 2);
        exp_q.push_back('{addr: 5'd10, data: 32'h0000_007F});
        load_op(3'b010, 2'b01, 32'h8765_4321, 5'd11, 1);
        exp_q.push_back('{addr: 5'd11, data: 32'h8765_4321});
        load_op(3'b011, 2'b00, 32'hCAFE_F00D, 5'd12, 2);
        exp_q.push_back('{addr: 5'd12, data: 32'hCAFE_F00D});
        load_op(3'b000, 2'b01, 32'hFFFF_FFFF, 5'd0, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin errors++; $display("FAIL load_count: got %0d writes want %0d", obs_n - obs_rd, exp_q.size()); end
        while (exp_q.size() != 0 && obs_rd < obs_n) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_mem[obs_rd] !== e) begin errors++; $display("FAIL load_write: got rd=%0d data=%h want rd=%0d data=%h", obs_mem[obs_rd].addr, obs_mem[obs_rd].data, e.addr, e.data); end
            obs_rd++;
        end
        exp_q.delete(); obs_rd = obs_n;
    endtask

    task automatic test_back_to_back();
        drive_op(2'b00, 1'b1, 5'd0, '0, 32'h1111_1111, '0, 3'b000, 2'b00);
        drive_op(2'b00, 1'b0, 5'd4, '0, 32'h2222_2222, '0, 3'b000, 2'b00);
        for (int k = 0; k < 3; k++) begin
            drive_op(2'b00, 1'b1, 5'(20 + k), '0, 32'hA000_0000 + 32'(k), '0, 3'b000, 2'b00);
            exp_q.push_back('{addr: 5'(20 + k), data: 32'hA000_0000 + 32'(k)});
        end
        release_bus();
        repeat (3) @(negedge clk);
        checks++;
        if (obs_n - obs_rd != 3) begin errors++; $display("FAIL b2b_count: got %0d writes want 3", obs_n - obs_rd); end
        else begin
            checks++;
            if (obs_cyc[obs_rd + 1] != obs_cyc[obs_rd] + 1 || obs_cyc[obs_rd + 2] != obs_cyc[obs_rd] + 2) begin
                errors++; $display("FAIL b2b_spacing: got cycles %0d %0d %0d want consecutive", obs_cyc[obs_rd], obs_cyc[obs_rd + 1], obs_cyc[obs_rd + 2]);
            end
        end
        while (exp_q.size() != 0 && obs_rd < obs_n) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_mem[obs_rd] !== e) begin errors++; $display("FAIL b2b_write: got rd=%0d data=%h want rd=%0d data=%h", obs_mem[obs_rd].addr, obs_mem[obs_rd].data, e.addr, e.data); end
            obs_rd++;
        end
        exp_q.delete(); obs_rd = obs_n;
    endtask

    task automatic test_flush();
        drive_op(2'b01, 1'b1, 5'd13, '0, '0, '0, 3'b010, 2'b00);
        release_bus();
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        @(posedge clk); #1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        drive_op(2'b00, 1'b1, 5'd14, '0, 32'h7777_7777, '0, 3'b000, 2'b00);
        flush = 1'b1;
        release_bus();
        drive_op(2'b01, 1'b1, 5'd15, '0, '0, '0, 3'b010, 2'b00);
        flush = 1'b1;
        release_bus();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready: got %b want 1", in_ready); end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_n != obs_rd) begin errors++; $display("FAIL flush_count: got %0d writes want 0", obs_n - obs_rd); end
        obs_rd = obs_n;
    endtask

    task automatic test_timeout();
        int err_start;
        err_start = err_n;
        drive_op(2'b01, 1'b1, 5'd16, '0, '0, '0, 3'b010, 2'b00);
        release_bus();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (err_timeout !== (k == 9)) begin errors++; $display("FAIL timeout_c%0d: got err=%b want %b", k, err_timeout, (k == 9)); end
        end
        // Response in the final counted cycle wins over the timeout
        load_op(3'b010, 2'b00, 32'h0BAD_CAFE, 5'd17, 8);
        exp_q.push_back('{addr: 5'd17, data: 32'h0BAD_CAFE});
        repeat (3) @(negedge clk);
        checks++;
        if (err_n - err_start != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", err_n - err_start); end
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin errors++; $display("FAIL timeout_count: got %0d writes want %0d", obs_n - obs_rd, exp_q.size()); end
        while (exp_q.size() != 0 && obs_rd < obs_n) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_mem[obs_rd] !== e) begin errors++; $display("FAIL timeout_write: got rd=%0d data=%h want rd=%0d data=%h", obs_mem[obs_rd].addr, obs_mem[obs_rd].data, e.addr, e.data); end
            obs_rd++;
        end
        exp_q.delete(); obs_rd = obs_n;
    endtask

    task automatic test_reset_mid_wait();
        drive_op(2'b01, 1'b1, 5'd18, '0, '0, '0, 3'b010, 2'b00);
        release_bus();
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        checks++; if (regW_addr !== '0 || regW_data !== '0 || regW_en !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got en=%b addr=%0d data=%h err=%b want all 0", regW_en, regW_addr, regW_data, err_timeout);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_n != obs_rd) begin errors++; $display("FAIL rst_mid_count: got %0d writes want 0", obs_n - obs_rd); end
        obs_rd = obs_n;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_link_imm();
        test_load();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
